// File: rtl/design1_wrapper_if.sv
// Command/status bundle for one BRAM controller port.
// The host side uses the master modport and the controller side uses the slave modport.
interface design1_wrapper_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  i_run;
  logic [ADDR_WIDTH-1:0] i_bramAddr;
  logic                  i_mode;
  logic [DATA_WIDTH-1:0] i_write_data;
  logic                  o_idle;
  logic                  o_write;
  logic                  o_read;
  logic [DATA_WIDTH-1:0] o_read_data;
  logic                  o_read_valid;
  logic                  o_done;

  modport master (
    output i_run, i_bramAddr, i_mode, i_write_data,
    input  o_idle, o_write, o_read, o_read_data, o_read_valid, o_done
  );

  modport slave (
    input  i_run, i_bramAddr, i_mode, i_write_data,
    output o_idle, o_write, o_read, o_read_data, o_read_valid, o_done
  );
endinterface

// File: rtl/design1_wrapper.sv
// Two single-access BRAM controllers sharing one true dual-port RAM.
// Controller 0 owns RAM port A and controller 1 owns RAM port B.

// One-shot read/write controller: IDLE -> RUN -> (WAIT) -> DONE -> IDLE.
module bram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic                  o_idle,
  output logic                  o_write,
  output logic                  o_read,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_read_valid,
  output logic                  o_done,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t                r_state;
  logic                  r_idle;
  logic                  r_write;
  logic                  r_read;
  logic                  r_done;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  // FSM with every status output registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idle      <= 1'b1;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_read_data <= '0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state <= S_RUN;
            r_idle  <= 1'b0;
            r_addr  <= i_addr;
            r_din   <= i_write_data;
            r_write <= i_mode;
            r_read  <= ~i_mode;
          end
        end
        S_RUN: begin
          // The RAM strobe is active during this cycle only
          r_write <= 1'b0;
          r_read  <= 1'b0;
          if (r_write) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // RAM output register holds the word addressed during RUN
          r_read_data <= i_ram_dout;
          r_valid     <= 1'b1;
          r_done      <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign o_idle       = r_idle;
  assign o_write      = r_write;
  assign o_read       = r_read;
  assign o_read_data  = r_read_data;
  assign o_read_valid = r_valid;
  assign o_done       = r_done;
  assign o_ram_en     = r_write | r_read;
  assign o_ram_we     = r_write;
  assign o_ram_addr   = r_addr;
  assign o_ram_din    = r_din;
endmodule

module design1_wrapper #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk_0,
  input  logic              reset_n_0,
  design1_wrapper_if.slave  cmd_0,
  design1_wrapper_if.slave  cmd_1
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  w_en_a, w_we_a, w_en_b, w_we_b;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b;
  logic [DATA_WIDTH-1:0] w_din_a, w_din_b;
  logic [DATA_WIDTH-1:0] r_dout_a, r_dout_b;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  bram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ctrl_0 (
    .clk          (clk_0),
    .rst_n        (reset_n_0),
    .i_run        (cmd_0.i_run),
    .i_addr       (cmd_0.i_bramAddr),
    .i_mode       (cmd_0.i_mode),
    .i_write_data (cmd_0.i_write_data),
    .o_idle       (cmd_0.o_idle),
    .o_write      (cmd_0.o_write),
    .o_read       (cmd_0.o_read),
    .o_read_data  (cmd_0.o_read_data),
    .o_read_valid (cmd_0.o_read_valid),
    .o_done       (cmd_0.o_done),
    .o_ram_en     (w_en_a),
    .o_ram_we     (w_we_a),
    .o_ram_addr   (w_addr_a),
    .o_ram_din    (w_din_a),
    .i_ram_dout   (r_dout_a)
  );

  bram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ctrl_1 (
    .clk          (clk_0),
    .rst_n        (reset_n_0),
    .i_run        (cmd_1.i_run),
    .i_addr       (cmd_1.i_bramAddr),
    .i_mode       (cmd_1.i_mode),
    .i_write_data (cmd_1.i_write_data),
    .o_idle       (cmd_1.o_idle),
    .o_write      (cmd_1.o_write),
    .o_read       (cmd_1.o_read),
    .o_read_data  (cmd_1.o_read_data),
    .o_read_valid (cmd_1.o_read_valid),
    .o_done       (cmd_1.o_done),
    .o_ram_en     (w_en_b),
    .o_ram_we     (w_we_b),
    .o_ram_addr   (w_addr_b),
    .o_ram_din    (w_din_b),
    .i_ram_dout   (r_dout_b)
  );

  // True dual-port RAM, read-first on both ports. Port A's write is issued
  // last so it wins when both ports write the same word in one cycle.
  always_ff @(posedge clk_0) begin
    if (w_en_b) begin
      r_dout_b <= r_mem[w_addr_b];
      if (w_we_b) r_mem[w_addr_b] <= w_din_b;
    end
    if (w_en_a) begin
      r_dout_a <= r_mem[w_addr_a];
      if (w_we_a) r_mem[w_addr_a] <= w_din_a;
    end
  end
endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for design1_wrapper: write/readback across ports, handshake
// timing, busy rejection, collisions and reset during a read.
module tb_design1_wrapper;
  logic clk_0;
  logic reset_n_0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rd;

  design1_wrapper_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) if0 ();
  design1_wrapper_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) if1 ();

  design1_wrapper #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk_0     (clk_0),
    .reset_n_0 (reset_n_0),
    .cmd_0     (if0),
    .cmd_1     (if1)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic start(input int p, input logic m, input logic [9:0] a, input logic [31:0] d);
    if (p == 0) begin
      if0.i_run = 1'b1; if0.i_mode = m; if0.i_bramAddr = a; if0.i_write_data = d;
    end else begin
      if1.i_run = 1'b1; if1.i_mode = m; if1.i_bramAddr = a; if1.i_write_data = d;
    end
  endtask

  task automatic stop(input int p);
    if (p == 0) if0.i_run = 1'b0;
    else        if1.i_run = 1'b0;
  endtask

  function automatic logic get_done(input int p);
    return (p == 0) ? if0.o_done : if1.o_done;
  endfunction
  function automatic logic get_valid(input int p);
    return (p == 0) ? if0.o_read_valid : if1.o_read_valid;
  endfunction
  function automatic logic get_idle(input int p);
    return (p == 0) ? if0.o_idle : if1.o_idle;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? if0.o_read_data : if1.o_read_data;
  endfunction

  // One complete command on port p, bounded wait for o_done
  task automatic run_cmd(input int p, input logic m, input logic [9:0] a,
                         input logic [31:0] d, output logic [31:0] r);
    int n;
    @(negedge clk_0);
    start(p, m, a, d);
    @(negedge clk_0);
    stop(p);
    n = 0;
    while (!get_done(p) && n < 8) begin
      @(negedge clk_0);
      n++;
    end
    check("cmd_done", {31'd0, get_done(p)}, 32'd1);
    check("cmd_valid", {31'd0, get_valid(p)}, {31'd0, ~m});
    r = get_rdata(p);
    $display("txn port=%0d %s addr=%0d wdata=%08h rdata=%08h", p, m ? "WR" : "RD", a, d, r);
    @(negedge clk_0);
    check("cmd_idle_after", {31'd0, get_idle(p)}, 32'd1);
  endtask

  initial begin
    reset_n_0 = 1'b0;
    if0.i_run = 1'b0; if0.i_mode = 1'b0; if0.i_bramAddr = '0; if0.i_write_data = '0;
    if1.i_run = 1'b0; if1.i_mode = 1'b0; if1.i_bramAddr = '0; if1.i_write_data = '0;

    // Reset values while reset is held
    #20;
    check("rst_idle0",  {31'd0, if0.o_idle}, 32'd1);
    check("rst_idle1",  {31'd0, if1.o_idle}, 32'd1);
    check("rst_flags0", {28'd0, if0.o_done, if0.o_read, if0.o_write, if0.o_read_valid}, 32'd0);
    check("rst_flags1", {28'd0, if1.o_done, if1.o_read, if1.o_write, if1.o_read_valid}, 32'd0);
    check("rst_rdata0", if0.o_read_data, 32'd0);
    check("rst_rdata1", if1.o_read_data, 32'd0);
    #2 reset_n_0 = 1'b1;

    // Port 0 writes data = address, port 1 reads back
    for (int i = 0; i < 10; i++) run_cmd(0, 1'b1, 10'(i), 32'(i), rd);
    for (int i = 1; i < 10; i++) begin
      run_cmd(1, 1'b0, 10'(i), 32'd0, rd);
      check("xread", rd, 32'(i));
    end
    repeat (3) @(negedge clk_0);
    check("hold9", if1.o_read_data, 32'd9);

    // Write handshake timing on port 0 (addr 20)
    @(negedge clk_0); start(0, 1'b1, 10'd20, 32'h0000_1234);
    @(negedge clk_0); stop(0);
    check("w_e0e1", {29'd0, if0.o_write, if0.o_done, if0.o_idle}, 32'b100);
    @(negedge clk_0);
    check("w_e1e2", {29'd0, if0.o_write, if0.o_done, if0.o_idle}, 32'b010);
    @(negedge clk_0);
    check("w_e2",   {29'd0, if0.o_write, if0.o_done, if0.o_idle}, 32'b001);
    $display("txn port=0 WR addr=20 wdata=00001234 (timed)");

    // Read handshake timing on port 1 (addr 20)
    @(negedge clk_0); start(1, 1'b0, 10'd20, 32'd0);
    @(negedge clk_0); stop(1);
    check("r_e0e1", {28'd0, if1.o_read, if1.o_done, if1.o_read_valid, if1.o_idle}, 32'b1000);
    @(negedge clk_0);
    check("r_e1e2", {28'd0, if1.o_read, if1.o_done, if1.o_read_valid, if1.o_idle}, 32'b0000);
    check("r_e1e2_data", if1.o_read_data, 32'd9);
    @(negedge clk_0);
    check("r_e2e3", {28'd0, if1.o_read, if1.o_done, if1.o_read_valid, if1.o_idle}, 32'b0110);
    check("r_e2e3_data", if1.o_read_data, 32'h0000_1234);
    @(negedge clk_0);
    check("r_e3", {28'd0, if1.o_read, if1.o_done, if1.o_read_valid, if1.o_idle}, 32'b0001);
    check("r_e3_hold", if1.o_read_data, 32'h0000_1234);
    $display("txn port=1 RD addr=20 rdata=%08h (timed)", if1.o_read_data);

    // Busy rejection: run re-asserted with another address during RUN and DONE
    run_cmd(0, 1'b1, 10'd30, 32'h3030_3030, rd);
    run_cmd(0, 1'b1, 10'd31, 32'h3131_3131, rd);
    @(negedge clk_0); start(0, 1'b1, 10'd30, 32'h0000_DEAD);
    @(negedge clk_0); start(0, 1'b1, 10'd31, 32'h0000_0BAD);
    @(negedge clk_0);
    check("busy_done", {31'd0, if0.o_done}, 32'd1);
    @(negedge clk_0); stop(0);
    $display("txn port=0 WR addr=30 wdata=0000dead (busy pulses to addr 31)");
    repeat (2) @(negedge clk_0);
    check("busy_idle", {31'd0, if0.o_idle}, 32'd1);
    run_cmd(1, 1'b0, 10'd31, 32'd0, rd);
    check("busy_31", rd, 32'h3131_3131);
    run_cmd(1, 1'b0, 10'd30, 32'd0, rd);
    check("busy_30", rd, 32'h0000_DEAD);

    // Collision: port 0 writes addr 5 while port 1 reads it
    @(negedge clk_0);
    start(0, 1'b1, 10'd5, 32'hA5A5_A5A5);
    start(1, 1'b0, 10'd5, 32'd0);
    @(negedge clk_0); stop(0); stop(1);
    repeat (2) @(negedge clk_0);
    check("coll_valid", {31'd0, if1.o_read_valid}, 32'd1);
    check("coll_old", if1.o_read_data, 32'd5);
    $display("txn port=0 WR / port=1 RD addr=5 rdata=%08h (collision)", if1.o_read_data);
    @(negedge clk_0);
    run_cmd(1, 1'b0, 10'd5, 32'd0, rd);
    check("coll_new", rd, 32'hA5A5_A5A5);

    // Collision: both ports write addr 7
    @(negedge clk_0);
    start(0, 1'b1, 10'd7, 32'h7000_0000);
    start(1, 1'b1, 10'd7, 32'h7111_1111);
    @(negedge clk_0); stop(0); stop(1);
    repeat (2) @(negedge clk_0);
    $display("txn port=0/1 WR addr=7 (collision)");
    run_cmd(0, 1'b0, 10'd7, 32'd0, rd);
    check("ww_p0", rd, 32'h7000_0000);
    run_cmd(1, 1'b0, 10'd7, 32'd0, rd);
    check("ww_p1", rd, 32'h7000_0000);

    // Reset asserted while port 1 is in WAIT
    @(negedge clk_0); start(1, 1'b0, 10'd20, 32'd0);
    @(negedge clk_0); stop(1);
    @(negedge clk_0);
    #2 reset_n_0 = 1'b0;
    #1;
    check("mrst_rdata", if1.o_read_data, 32'd0);
    check("mrst_idle", {31'd0, if1.o_idle}, 32'd1);
    #9 reset_n_0 = 1'b1;
    $display("txn port=1 RD addr=20 aborted by reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_0);
      check("mrst_nopulse", {30'd0, if1.o_done, if1.o_read_valid}, 32'd0);
    end
    check("mrst_rdata_held", if1.o_read_data, 32'd0);
    run_cmd(1, 1'b0, 10'd20, 32'd0, rd);
    check("mrst_next", rd, 32'h0000_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
